block_assembler: RTL and testbench

BLOCK_ASSEMBLER -- requirements
Module: block_assembler

---
 rtl/block_assembler_pkg.sv | 14 +
 rtl/block_assembler.sv | 93 +++++++++
 tb/tb_block_assembler.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/block_assembler_pkg.sv
// Shared AES block constants and the assembler state encoding.
package block_assembler_pkg;

   localparam int BLOCK_W         = 128;
   localparam int BYTE_W          = 8;
   localparam int BYTES_PER_BLOCK = 16;
   localparam int CNT_W           = $clog2(BYTES_PER_BLOCK);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_e;

endpackage

// File: rtl/block_assembler.sv
// Packs an MSB-first byte stream into 128-bit blocks, with an idle timeout
// that discards a stalled partial block and a synchronous clear.
module block_assembler
   import block_assembler_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [BYTE_W-1:0]  rx_data,
   input  logic               rx_valid,
   input  logic               sync_clr,
   output logic [BLOCK_W-1:0] block,
   output logic               write_en,
   output logic               busy,
   output logic               timeout_err
);

   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_BLOCK - 1);

   state_e                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [15:0]               timer_q, timer_d;
   // Only bytes 0..14 are staged; byte 15 is merged straight into block_q.
   logic [BLOCK_W-BYTE_W-1:0] shift_q, shift_d;
   logic [BLOCK_W-1:0]        block_q, block_d;
   logic                      we_q, we_d;
   logic                      to_q, to_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      timer_d = timer_q;
      shift_d = shift_q;
      block_d = block_q;
      we_d    = 1'b0;
      to_d    = 1'b0;

      if (sync_clr) begin
         state_d = IDLE;
         cnt_d   = '0;
         timer_d = '0;
      end else if (rx_valid) begin
         shift_d = {shift_q[BLOCK_W-2*BYTE_W-1:0], rx_data};
         cnt_d   = cnt_q + 1'b1;
         timer_d = '0;
         if (cnt_q == CNT_LAST) begin
            block_d = {shift_q, rx_data};
            we_d    = 1'b1;
            state_d = IDLE;
         end else begin
            state_d = FILL;
         end
      end else if (state_q == FILL) begin
         // This idle cycle is the TIMEOUT_CYCLES-th in a row.
         if (timer_q == TIMER_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            timer_d = '0;
            to_d    = 1'b1;
         end else begin
            timer_d = timer_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         timer_q <= '0;
         shift_q <= '0;
         block_q <= '0;
         we_q    <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         timer_q <= timer_d;
         shift_q <= shift_d;
         block_q <= block_d;
         we_q    <= we_d;
         to_q    <= to_d;
      end
   end

   assign block       = block_q;
   assign write_en    = we_q;
   assign busy        = (state_q == FILL);
   assign timeout_err = to_q;

endmodule

// File: tb/tb_block_assembler.sv
// Self-checking bench for block_assembler: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_block_assembler;

   localparam int TO = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [7:0]   rx_data = '0;
   logic         rx_valid = 1'b0;
   logic         sync_clr = 1'b0;
   logic [127:0] block;
   logic         write_en;
   logic         busy;
   logic         timeout_err;

   block_assembler #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .sync_clr   (sync_clr),
      .block      (block),
      .write_en   (write_en),
      .busy       (busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       clr;
      logic       exp_we;
      logic       exp_busy;
      logic       exp_to;
   } vec_t;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int we_cycles[$];

   // Reference model: bytes of the partial block and the current idle run.
   logic [7:0]   model_q[$];
   int           idle_run = 0;
   logic [127:0] m_block = '0;
   logic         m_we = 1'b0;
   logic         m_to = 1'b0;

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void model_edge(logic v, logic [7:0] d, logic clr);
      m_we = 1'b0;
      m_to = 1'b0;
      if (clr) begin
         model_q.delete();
         idle_run = 0;
      end else if (v) begin
         model_q.push_back(d);
         idle_run = 0;
         if (model_q.size() == 16) begin
            for (int i = 0; i < 16; i++) m_block[127-8*i -: 8] = model_q[i];
            m_we = 1'b1;
            model_q.delete();
         end
      end else if (model_q.size() > 0) begin
         idle_run++;
         if (idle_run >= TO) begin
            m_to = 1'b1;
            model_q.delete();
            idle_run = 0;
         end
      end
   endfunction

   task automatic step(logic v, logic [7:0] d, logic clr);
      rx_valid = v;
      rx_data  = d;
      sync_clr = clr;
      @(posedge clk);
      model_edge(v, d, clr);
      cyc++;
      #1;
      check("block", block, m_block);
      check("write_en", {127'b0, write_en}, {127'b0, m_we});
      check("busy", {127'b0, busy}, {127'b0, (model_q.size() > 0)});
      check("timeout_err", {127'b0, timeout_err}, {127'b0, m_to});
      if (write_en) begin
         we_cycles.push_back(cyc);
         $display("[TB] cycle %0d write_en block=%h", cyc, block);
      end
      if (timeout_err) $display("[TB] cycle %0d timeout_err", cyc);
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      sync_clr = 1'b0;
      reset    = 1'b0;
      model_q.delete();
      idle_run = 0;
      m_block  = '0;
      m_we     = 1'b0;
      m_to     = 1'b0;
      #2;
      check("rst_block", block, 128'h0);
      check("rst_we", {127'b0, write_en}, 128'h0);
      check("rst_busy", {127'b0, busy}, 128'h0);
      check("rst_to", {127'b0, timeout_err}, 128'h0);
      $display("[TB] reset applied at cycle %0d", cyc);
      @(posedge clk);
      #3;
      reset = 1'b1;
   endtask

   vec_t tbl[17];
   logic [31:0] dbf = 32'hDEADBEEF;

   initial begin
      for (int i = 0; i < 16; i++)
         tbl[i] = '{v: 1'b1, d: 8'(i * 17), clr: 1'b0,
                    exp_we: (i == 15), exp_busy: (i != 15), exp_to: 1'b0};
      tbl[16] = '{v: 1'b0, d: 8'h00, clr: 1'b0, exp_we: 1'b0, exp_busy: 1'b0, exp_to: 1'b0};

      do_reset();

      // Bytes 00,11,..,FF straight after reset release.
      for (int i = 0; i < 17; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].clr);
         check("tbl_we", {127'b0, write_en}, {127'b0, tbl[i].exp_we});
         check("tbl_busy", {127'b0, busy}, {127'b0, tbl[i].exp_busy});
         check("tbl_to", {127'b0, timeout_err}, {127'b0, tbl[i].exp_to});
         $display("[TB] vec %0d v=%0b d=%h clr=%0b -> we=%0b busy=%0b to=%0b",
                  i, tbl[i].v, tbl[i].d, tbl[i].clr, write_en, busy, timeout_err);
      end
      check("blk_seq", block, 128'h00112233445566778899AABBCCDDEEFF);

      // 32 back-to-back bytes.
      we_cycles.delete();
      for (int k = 0; k < 32; k++)
         step(1'b1, (k < 16) ? 8'(k * 17) : 8'((31 - k) * 17), 1'b0);
      check("b2b_blk", block, 128'hFFEEDDCCBBAA99887766554433221100);
      step(1'b0, 8'h00, 1'b0);
      check("b2b_npulse", 128'(we_cycles.size()), 128'd2);
      if (we_cycles.size() == 2) check("b2b_gap", 128'(we_cycles[1] - we_cycles[0]), 128'd16);

      // Partial block of 5 bytes then TO idle cycles.
      step(1'b1, 8'hDE, 1'b0); step(1'b1, 8'hAD, 1'b0); step(1'b1, 8'hBE, 1'b0);
      step(1'b1, 8'hEF, 1'b0); step(1'b1, 8'hDE, 1'b0);
      for (int k = 0; k < TO; k++) begin
         step(1'b0, 8'h00, 1'b0);
         check("to_pulse", {127'b0, timeout_err}, {127'b0, (k == TO - 1)});
      end
      check("to_busy", {127'b0, busy}, 128'h0);
      check("to_blk", block, 128'hFFEEDDCCBBAA99887766554433221100);
      for (int k = 0; k < 16; k++) step(1'b1, dbf[31-8*(k%4) -: 8], 1'b0);
      check("dbf_blk", block, 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF);
      check("dbf_we", {127'b0, write_en}, 128'h1);

      // Byte arrives on the exact cycle the timeout would fire.
      for (int k = 0; k < 3; k++) step(1'b1, 8'(8'h10 + k), 1'b0);
      for (int k = 0; k < TO - 1; k++) step(1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h13, 1'b0);
      check("race_to", {127'b0, timeout_err}, 128'h0);
      check("race_busy", {127'b0, busy}, 128'h1);
      for (int k = 4; k < 16; k++) step(1'b1, 8'(8'h10 + k), 1'b0);
      check("race_blk", block, 128'h101112131415161718191A1B1C1D1E1F);
      check("race_we", {127'b0, write_en}, 128'h1);

      // Reset after 9 bytes.
      we_cycles.delete();
      for (int k = 0; k < 9; k++) step(1'b1, 8'h55, 1'b0);
      do_reset();
      for (int k = 0; k < 16; k++) step(1'b1, (k % 2 == 0) ? 8'hFF : 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      check("rst9_blk", block, 128'hFF00FF00FF00FF00FF00FF00FF00FF00);
      check("rst9_npulse", 128'(we_cycles.size()), 128'd1);

      // sync_clr together with the 16th byte.
      for (int k = 0; k < 15; k++) step(1'b1, 8'h77, 1'b0);
      step(1'b1, 8'h77, 1'b1);
      check("clr_we", {127'b0, write_en}, 128'h0);
      check("clr_busy", {127'b0, busy}, 128'h0);
      step(1'b0, 8'h00, 1'b0);
      check("clr_we2", {127'b0, write_en}, 128'h0);
      for (int k = 0; k < 16; k++) step(1'b1, 8'(8'hA0 + k), 1'b0);
      check("clr_blk", block, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);

      // Randomized traffic with idle bursts, clears and occasional resets.
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = int'($urandom_range(0, 999));
         if (r < 3) begin
            do_reset();
         end else if (r < 40) begin
            int gap;
            gap = int'($urandom_range(TO - 3, TO + 2));
            for (int g = 0; g < gap; g++) step(1'b0, 8'($urandom), 1'b0);
         end else begin
            step(($urandom_range(0, 99) < 75), 8'($urandom), ($urandom_range(0, 99) < 2));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
